// File: rtl/rf_wb_queue.sv
// rf_wb_queue: 4-entry in-order write-back queue in front of a register-file write port.
// Ports: clk, reset_n (async, active-low); req_valid/req_ready/req_addr/req_data (producer);
//   wb_stall, rf_write/rf_addr_w/rf_data_w (register-file write port);
//   q_addr -> q_hit/q_data (forwarding lookup); pending_cnt (occupancy 0..4).
// Optional feature: define RF_WB_FWD_EN to build the q_addr forwarding comparators.
module rf_wb_queue #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_addr,
  input  logic [WORD_SIZE-1:0] req_data,
  input  logic                 wb_stall,
  output logic                 rf_write,
  output logic [1:0]           rf_addr_w,
  output logic [WORD_SIZE-1:0] rf_data_w,
  input  logic [1:0]           q_addr,
  output logic                 q_hit,
  output logic [WORD_SIZE-1:0] q_data,
  output logic [2:0]           pending_cnt
);

  logic [1:0]           r_addr [DEPTH];
  logic [WORD_SIZE-1:0] r_data [DEPTH];
  logic [1:0]           r_rd_ptr;
  logic [1:0]           r_wr_ptr;
  logic [2:0]           r_cnt;

  logic w_enq;
  logic w_deq;
  logic w_nonempty;

  assign w_nonempty  = (r_cnt != 3'd0);
  assign req_ready   = (r_cnt < 3'(DEPTH));
  assign w_enq       = req_valid && req_ready;
  assign rf_write    = w_nonempty && !wb_stall;
  assign w_deq       = rf_write;
  assign pending_cnt = r_cnt;

  // Stale slots may hold old data; gate the head view with occupancy.
  assign rf_addr_w = w_nonempty ? r_addr[r_rd_ptr] : 2'd0;
  assign rf_data_w = w_nonempty ? r_data[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_cnt    <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 2'd0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_wr_ptr] <= req_addr;
        r_data[r_wr_ptr] <= req_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef RF_WB_FWD_EN
  logic                 w_hit;
  logic [WORD_SIZE-1:0] w_fdata;
  logic [1:0]           w_idx;

  // Walk oldest to youngest so the last match wins; the incoming
  // request is not yet stored and so never participates.
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    w_idx   = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + 2'(i);
      if ((3'(i) < r_cnt) && (r_addr[w_idx] == q_addr)) begin
        w_hit   = 1'b1;
        w_fdata = r_data[w_idx];
      end
    end
  end

  assign q_hit  = w_hit;
  assign q_data = w_fdata;
`else
  logic w_unused_qaddr;
  assign w_unused_qaddr = ^q_addr;
  assign q_hit  = 1'b0;
  assign q_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed self-checking bench for rf_wb_queue.
// Observed register-file writes are logged and compared to hand-written lists.
module tb_rf_wb_queue;

  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_addr;
  logic [W-1:0] req_data;
  logic         wb_stall;
  logic         rf_write;
  logic [1:0]   rf_addr_w;
  logic [W-1:0] rf_data_w;
  logic [1:0]   q_addr;
  logic         q_hit;
  logic [W-1:0] q_data;
  logic [2:0]   pending_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [17:0] wr_log[$];

  rf_wb_queue #(.WORD_SIZE(W), .DEPTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .wb_stall(wb_stall),
    .rf_write(rf_write),
    .rf_addr_w(rf_addr_w),
    .rf_data_w(rf_data_w),
    .q_addr(q_addr),
    .q_hit(q_hit),
    .q_data(q_data),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset_n && rf_write)
      wr_log.push_back({rf_addr_w, rf_data_w});

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [1:0] a,
                       input logic [W-1:0] d);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic chk_log(input string tag,
                         input int idx,
                         input logic [1:0] a,
                         input logic [W-1:0] d);
    logic [17:0] got;
    got = (idx < wr_log.size()) ? wr_log[idx] : 18'h3ffff;
    chk(tag, {14'd0, got}, {14'd0, a, d});
  endtask

  initial begin
    reset_n = 1'b0;
    wb_stall = 1'b0;
    q_addr = 2'd0;
    drive(1'b0, 2'd0, '0);
    #2;
    chk("rst_rf_write", {31'd0, rf_write}, 0);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_cnt", {29'd0, pending_cnt}, 0);
    chk("rst_qhit", {31'd0, q_hit}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // basic flow
    wr_log.delete();
    drive(1'b1, 2'd2, 16'h1234);
    #1;
    chk("basic_nobypass", {31'd0, rf_write}, 0);
    tick();
    drive(1'b0, 2'd0, '0);
    #1;
    chk("basic_wr", {31'd0, rf_write}, 1);
    chk("basic_addr", {30'd0, rf_addr_w}, 2);
    chk("basic_data", {16'd0, rf_data_w}, 32'h1234);
    chk("basic_cnt1", {29'd0, pending_cnt}, 1);
    tick();
    chk("basic_cnt0", {29'd0, pending_cnt}, 0);
    chk("basic_idle", {31'd0, rf_write}, 0);
    chk("basic_nlog", wr_log.size(), 1);
    chk_log("basic_log", 0, 2'd2, 16'h1234);

    // fill under stall, 5 offered, 4 accepted
    wr_log.delete();
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i), 16'h0100 + 16'(i));
      tick();
    end
    drive(1'b0, 2'd0, '0);
    #1;
    chk("fill_cnt", {29'd0, pending_cnt}, 4);
    chk("fill_ready", {31'd0, req_ready}, 0);
    chk("fill_nowr", {31'd0, rf_write}, 0);
    chk("fill_head", {16'd0, rf_data_w}, 32'h0100);
    wb_stall = 1'b0;
    #1;
    chk("fill_rel_wr", {31'd0, rf_write}, 1);
    tick();
    tick();
    tick();
    tick();
    chk("fill_cnt0", {29'd0, pending_cnt}, 0);
    chk("fill_nlog", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_log("fill_log", i, 2'(i), 16'h0100 + 16'(i));

    // forwarding
    wr_log.delete();
    wb_stall = 1'b1;
    drive(1'b1, 2'd1, 16'hAAAA);
    tick();
    drive(1'b1, 2'd1, 16'hBBBB);
    tick();
    drive(1'b1, 2'd1, 16'hCCCC);
    q_addr = 2'd1;
    #1;
    chk("fwd_hit", {31'd0, q_hit}, {31'd0, FWD});
    chk("fwd_young", {16'd0, q_data}, FWD ? 32'hBBBB : 32'h0);
    drive(1'b0, 2'd0, '0);
    q_addr = 2'd3;
    #1;
    chk("fwd_miss", {31'd0, q_hit}, 0);
    chk("fwd_miss_d", {16'd0, q_data}, 0);
    q_addr = 2'd1;
    wb_stall = 1'b0;
    #1;
    chk("fwd_headwr", {31'd0, q_hit}, {31'd0, FWD});
    tick();
    chk("fwd_after1", {16'd0, q_data}, FWD ? 32'hBBBB : 32'h0);
    tick();
    chk("fwd_empty", {31'd0, q_hit}, 0);
    chk("fwd_nlog", wr_log.size(), 2);
    chk_log("fwd_log0", 0, 2'd1, 16'hAAAA);
    chk_log("fwd_log1", 1, 2'd1, 16'hBBBB);

    // wrap-around with concurrent traffic
    wr_log.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'(i), 16'h0200 + 16'(i));
      tick();
      chk("wrap_cnt", {29'd0, pending_cnt}, 1);
    end
    drive(1'b0, 2'd0, '0);
    tick();
    chk("wrap_cnt0", {29'd0, pending_cnt}, 0);
    chk("wrap_nlog", wr_log.size(), 10);
    for (int i = 0; i < 10; i++)
      chk_log("wrap_log", i, 2'(i), 16'h0200 + 16'(i));

    // reset mid-operation
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd3, 16'h0300 + 16'(i));
      tick();
    end
    drive(1'b0, 2'd0, '0);
    q_addr = 2'd3;
    #1;
    chk("mrst_cnt3", {29'd0, pending_cnt}, 3);
    wr_log.delete();
    wb_stall = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mrst_cnt", {29'd0, pending_cnt}, 0);
    chk("mrst_wr", {31'd0, rf_write}, 0);
    chk("mrst_addr", {30'd0, rf_addr_w}, 0);
    chk("mrst_data", {16'd0, rf_data_w}, 0);
    chk("mrst_ready", {31'd0, req_ready}, 1);
    chk("mrst_qhit", {31'd0, q_hit}, 0);
    chk("mrst_qdata", {16'd0, q_data}, 0);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mrst_nlog", wr_log.size(), 0);
    chk("mrst_idle", {31'd0, rf_write}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4 (fixed), meaning number of pending write-back entries.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its posedge.
REQ-004 The block SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  1  producer offers a write-back.
REQ-006 The block SHALL have port req_ready  output  1  queue can accept a write-back.
REQ-007 The block SHALL have port req_addr  input  2  destination register index.
REQ-008 The block SHALL have port req_data  input  WORD_SIZE  value to write.
REQ-009 The block SHALL have port wb_stall  input  1  register-file write port unavailable this cycle.
REQ-010 The block SHALL have port rf_write  output  1  write enable to the register file.
REQ-011 The block SHALL have port rf_addr_w  output  2  write address to the register file.
REQ-012 The block SHALL have port rf_data_w  output  WORD_SIZE  write data to the register file.
REQ-013 The block SHALL have port q_addr  input  2  forwarding lookup index.
REQ-014 The block SHALL have port q_hit  output  1  a pending entry targets q_addr.
REQ-015 The block SHALL have port q_data  output  WORD_SIZE  data of youngest pending entry matching q_addr.
REQ-016 The block SHALL have port pending_cnt  output  3  number of occupied entries, 0..4.

Function
REQ-017 Storage SHALL be a 4-entry circular FIFO of {addr, data} with 2-bit read and write pointers that wrap 3->0.
REQ-018 req_ready SHALL equal (pending_cnt < 4), independent of dequeue activity in the same cycle.
REQ-019 An entry SHALL be enqueued at a posedge where req_valid && req_ready; req_valid with req_ready low is ignored and state is unchanged.
REQ-020 rf_write SHALL be combinational: (pending_cnt != 0) && !wb_stall.
REQ-021 rf_addr_w and rf_data_w SHALL always show the head entry; when pending_cnt = 0 they SHALL be 0.
REQ-022 The head SHALL be dequeued at each posedge where rf_write is 1.
REQ-023 Writes SHALL reach the register file in strict acceptance order; same-address entries are never merged or reordered.
REQ-024 Minimum latency SHALL be: accepted at edge N, rf_write high during cycle N..N+1, register file updated at edge N+1.
REQ-025 Simultaneous enqueue and dequeue SHALL leave pending_cnt unchanged and advance both pointers.
REQ-026 An incoming request SHALL never bypass the FIFO to rf_* in the same cycle; an empty queue gives rf_write = 0.
REQ-027 wb_stall SHALL hold rf_write at 0 and freeze the head; enqueue continues until full.
REQ-028 q_hit/q_data SHALL cover all occupied entries, including the head being written this cycle, and SHALL exclude the incoming request.
REQ-029 Among multiple matches, q_data SHALL come from the most recently enqueued match; with no match, q_hit = 0 and q_data = 0.

Reset
REQ-030 reset_n low SHALL asynchronously clear both pointers and pending_cnt, and SHALL discard all entries.
REQ-031 During and after reset, rf_write = 0, rf_addr_w = 0, rf_data_w = 0, q_hit = 0, q_data = 0, and req_ready = 1.
REQ-032 Reset asserted mid-operation SHALL issue no further write from pre-reset entries.

Configuration
REQ-033 Macro RF_WB_FWD_EN defined SHALL enable the q_addr lookup logic per REQ-028/029.
REQ-034 Macro RF_WB_FWD_EN undefined SHALL tie q_hit and q_data to 0, remove the comparators, and keep all other ports and behaviour unchanged.

Verification
REQ-035 Bench SHALL cover basic flow: enqueue (addr 2, 16'h1234) with wb_stall = 0 -> next cycle rf_write = 1, rf_addr_w = 2, rf_data_w = 16'h1234; pending_cnt returns to 0.
REQ-036 Bench SHALL cover fill under stall: wb_stall = 1, offer 5 requests -> 4 accepted, req_ready = 0, pending_cnt = 4; release the stall -> 4 writes on consecutive cycles in order.
REQ-037 Bench SHALL cover forwarding (RF_WB_FWD_EN defined): stall, enqueue (1, 16'hAAAA) then (1, 16'hBBBB), q_addr = 1 -> q_hit = 1, q_data = 16'hBBBB; q_addr = 3 -> q_hit = 0.
REQ-038 Bench SHALL cover wrap-around with concurrent traffic: 10 back-to-back requests with no stall -> pointers wrap, pending_cnt stays 1, and all 10 writes appear in order.
REQ-039 Bench SHALL cover reset mid-operation: pending_cnt = 3, pulse reset_n low between edges -> outputs 0 immediately, req_ready = 1, and no further rf_write.
REQ-040 Bench SHALL cover macro off: RF_WB_FWD_EN undefined, repeat REQ-037 stimulus -> q_hit = 0, q_data = 0, and the write sequence is identical.
